// File: rtl/dw_shad_scan_ctrl.sv
// Scan-side controller for a shadow-register chain: optional capture cycle, then a
// WIDTH-bit shift that unloads SO into dout while loading a pattern on SI.
module dw_shad_scan_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             capture_i,
  input  logic [WIDTH-1:0] load_data,
  input  logic             abort_i,
  output logic             shad_clk_en,
  output logic             se_o,
  output logic             si_o,
  input  logic             so_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   load_q, load_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               shad_clk_en_q, shad_clk_en_d;
  logic               se_q, se_d;
  logic               si_q, si_d;
  logic               out_valid_q, out_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      load_q        <= '0;
      dout_q        <= '0;
      shad_clk_en_q <= 1'b0;
      se_q          <= 1'b0;
      si_q          <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      load_q        <= load_d;
      dout_q        <= dout_d;
      shad_clk_en_q <= shad_clk_en_d;
      se_q          <= se_d;
      si_q          <= si_d;
      out_valid_q   <= out_valid_d;
    end
  end

  // Abort overrides every transition; dout keeps whatever was shifted in so far.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    dout_d  = dout_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            load_d  = load_data;
            cnt_d   = '0;
            state_d = capture_i ? CAPTURE : SHIFT;
          end
        end
        CAPTURE: state_d = SHIFT;
        SHIFT: begin
          for (int b = 0; b < WIDTH; b++) begin
            if (b == WIDTH - 1 - int'(cnt_q)) dout_d[b] = so_i;
          end
          load_d = {load_q[WIDTH-2:0], 1'b0};
          if (cnt_q == LAST) state_d = DONE;
          else               cnt_d   = cnt_q + CNT_W'(1);
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Chain-facing outputs are registered from the next state so they never glitch.
  always_comb begin
    shad_clk_en_d = (state_d == CAPTURE) || (state_d == SHIFT);
    se_d          = (state_d == SHIFT);
    si_d          = se_d ? load_d[WIDTH-1] : 1'b0;
    out_valid_d   = (state_d == DONE);
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign shad_clk_en = shad_clk_en_q;
  assign se_o        = se_q;
  assign si_o        = si_q;
  assign out_valid   = out_valid_q;
  assign dout        = dout_q;

endmodule

// File: tb/tb_dw_shad_scan_ctrl.sv
// Bench for dw_shad_scan_ctrl: a behavioural shadow chain plus table-driven scan operations
// and hand-written sequences for DONE hold, abort, mid-shift reset and back-to-back requests.
module tb_dw_shad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_valid, start_ready, capture_i, abort_i;
  logic [7:0] load_data, dout;
  logic       shad_clk_en, se_o, si_o, so_i;
  logic       out_valid, out_ready, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dw_shad_scan_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .capture_i(capture_i), .load_data(load_data), .abort_i(abort_i),
    .shad_clk_en(shad_clk_en), .se_o(se_o), .si_o(si_o), .so_i(so_i),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .busy(busy)
  );

  // Shadow chain: SO is the MSB, SI enters at the LSB; capture loads sys_out.
  logic [7:0] chain, sys_out, pre_val;
  logic       pre_en;
  always @(posedge clk) begin
    if (pre_en)           chain <= pre_val;
    else if (shad_clk_en) chain <= se_o ? {chain[6:0], si_o} : sys_out;
  end
  assign so_i = chain[7];

  typedef struct {
    logic       cap;
    logic [7:0] pre;
    logic [7:0] sys;
    logic [7:0] load;
    logic [7:0] exp_dout;
    int         lat;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] v);
    pre_en = 1'b1;
    pre_val = v;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic start_op(input logic cap, input logic [7:0] load);
    start_valid = 1'b1;
    capture_i = cap;
    load_data = load;
    chk("start_ready_idle", start_ready, 1);
    tick();
    start_valid = 1'b0;
    capture_i = ~cap;
    load_data = ~load;
  endtask

  task automatic wait_valid(output int cyc, output int pulses);
    cyc = 0;
    pulses = 0;
    while (!out_valid && cyc < 40) begin
      if (shad_clk_en) pulses++;
      tick();
      cyc++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_cleared", out_valid, 0);
    chk("busy_cleared", busy, 0);
  endtask

  initial begin
    int cyc, pulses;
    vecs[0] = '{cap: 1'b1, pre: 8'h00, sys: 8'hA5, load: 8'h3C, exp_dout: 8'hA5, lat: 9};
    vecs[1] = '{cap: 1'b0, pre: 8'h81, sys: 8'h00, load: 8'hFF, exp_dout: 8'h81, lat: 8};
    vecs[2] = '{cap: 1'b1, pre: 8'hFF, sys: 8'h00, load: 8'h96, exp_dout: 8'h00, lat: 9};
    vecs[3] = '{cap: 1'b0, pre: 8'h3C, sys: 8'hFF, load: 8'h5A, exp_dout: 8'h3C, lat: 8};

    rst_n = 1'b0; start_valid = 1'b0; capture_i = 1'b0; load_data = '0;
    abort_i = 1'b0; out_ready = 1'b0; pre_en = 1'b0; pre_val = '0; sys_out = '0;
    tick(); tick();
    chk("rst_shad_clk_en", shad_clk_en, 0);
    chk("rst_se", se_o, 0);
    chk("rst_si", si_o, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_start_ready", start_ready, 1);

    for (int i = 0; i < 4; i++) begin
      preload(vecs[i].pre);
      sys_out = vecs[i].sys;
      start_op(vecs[i].cap, vecs[i].load);
      wait_valid(cyc, pulses);
      chk($sformatf("v%0d_latency", i), cyc, vecs[i].lat);
      chk($sformatf("v%0d_pulses", i), pulses, vecs[i].lat);
      chk($sformatf("v%0d_dout", i), dout, vecs[i].exp_dout);
      chk($sformatf("v%0d_chain", i), chain, vecs[i].load);
      chk($sformatf("v%0d_busy_done", i), busy, 1);
      finish_op();
    end

    // DONE held for 5 cycles with a competing request that must be ignored
    preload(8'hC3);
    sys_out = 8'h99;
    start_op(1'b1, 8'h0F);
    wait_valid(cyc, pulses);
    chk("hold_latency", cyc, 9);
    start_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("hold_out_valid", out_valid, 1);
      chk("hold_dout", dout, 8'h99);
      chk("hold_shad_clk_en", shad_clk_en, 0);
      chk("hold_se", se_o, 0);
      chk("hold_start_ready", start_ready, 0);
      tick();
    end
    start_valid = 1'b0;
    finish_op();
    chk("hold_chain", chain, 8'h0F);

    // Abort at SHIFT cycle 3
    preload(8'hF0);
    start_op(1'b0, 8'hAA);
    tick(); tick(); tick();
    chk("abort_pre_se", se_o, 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_se", se_o, 0);
    chk("abort_shad_clk_en", shad_clk_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_start_ready", start_ready, 1);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) pulses++;
      tick();
    end
    chk("abort_no_out_valid", pulses, 0);

    // Asynchronous reset at SHIFT cycle 5 (after one capture cycle)
    preload(8'h00);
    sys_out = 8'h5A;
    start_op(1'b1, 8'hFF);
    for (int k = 0; k < 6; k++) tick();
    chk("rstmid_pre_se", se_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_shad_clk_en", shad_clk_en, 0);
    chk("rstmid_se", se_o, 0);
    chk("rstmid_si", si_o, 0);
    chk("rstmid_dout", dout, 0);
    chk("rstmid_busy", busy, 0);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (shad_clk_en) pulses++;
    end
    chk("rstmid_no_pulses", pulses, 0);
    rst_n = 1'b1;
    tick();
    preload(8'h6E);
    start_op(1'b0, 8'h21);
    wait_valid(cyc, pulses);
    chk("rstmid_rerun_latency", cyc, 8);
    chk("rstmid_rerun_dout", dout, 8'h6E);
    chk("rstmid_rerun_chain", chain, 8'h21);
    finish_op();

    // Back-to-back: request held across out_ready is taken one cycle later
    preload(8'h12);
    start_op(1'b0, 8'h34);
    wait_valid(cyc, pulses);
    chk("b2b_first_dout", dout, 8'h12);
    out_ready = 1'b1;
    start_valid = 1'b1;
    capture_i = 1'b0;
    load_data = 8'h77;
    tick();
    out_ready = 1'b0;
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_start_ready", start_ready, 1);
    chk("b2b_idle_out_valid", out_valid, 0);
    tick();
    start_valid = 1'b0;
    load_data = 8'h00;
    chk("b2b_accepted_busy", busy, 1);
    wait_valid(cyc, pulses);
    chk("b2b_second_latency", cyc, 8);
    chk("b2b_second_dout", dout, 8'h34);
    chk("b2b_second_chain", chain, 8'h77);
    finish_op();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
